// File: rtl/bw_mult_pkg.sv
// Shared types and Baugh-Wooley helpers for the iterative signed multiplier.
// Helpers work at the maximum operand width; callers truncate to their own width.
package bw_mult_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MAX_N = 32;

  // 2^n + 2^(2n-1): restores the sign terms dropped by the inverted edge bits.
  function automatic logic [2*MAX_N-1:0] bw_corr(input int n);
    logic [2*MAX_N-1:0] c;
    int                 k;
    c = '0;
    k = 2 * n - 1;
    c[n[5:0]] = 1'b1;
    c[k[5:0]] = 1'b1;
    return c;
  endfunction

  function automatic logic [MAX_N-1:0] bw_row(input logic [MAX_N-1:0] a,
                                              input logic [MAX_N-1:0] b,
                                              input int               i,
                                              input int               n);
    logic [MAX_N-1:0] r;
    r = '0;
    for (int j = 0; j < MAX_N; j++) begin
      if (j < n) begin
        r[j[4:0]] = a[j[4:0]] & b[i[4:0]];
        if ((i == n - 1) != (j == n - 1)) r[j[4:0]] = ~r[j[4:0]];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fa.sv
// Full-adder cell.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/ha.sv
// Half-adder cell.
module ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// File: rtl/ripple_adder.sv
// W-bit ripple-carry adder built from ha/fa cells; the result wraps modulo 2^W.
module ripple_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);
  logic [W-2:0] c;

  ha u_ha0 (.a(a[0]), .b(b[0]), .s(sum[0]), .c(c[0]));

  for (genvar k = 1; k < W; k++) begin : g_bit
    if (k < W - 1) begin : g_mid
      fa u_fa (.a(a[k]), .b(b[k]), .ci(c[k-1]), .s(sum[k]), .co(c[k]));
    end else begin : g_top
      fa u_fa (.a(a[k]), .b(b[k]), .ci(c[k-1]), .s(sum[k]), .co());
    end
  end
endmodule

// File: rtl/bw_seq_mult.sv
// Iterative signed N x N Baugh-Wooley multiplier: one partial-product row per clock.
// state | meaning
// IDLE  | waiting for start; product holds the last result
// RUN   | accumulating row cnt into acc; completes on row N-1
module bw_seq_mult
  import bw_mult_pkg::*;
#(
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic signed [N-1:0]   a,
  input  logic signed [N-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic signed [2*N-1:0] product
);
  localparam int W  = 2 * N;
  localparam int CW = $clog2(N) + 1;
  typedef logic [W-1:0] word_t;
  localparam word_t CORR = word_t'(bw_corr(N));

  state_t         state, state_nxt;
  logic [W-1:0]   acc, acc_nxt, addend, sum, product_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [N-1:0]   a_r, b_r, a_nxt, b_nxt;
  logic           done_nxt;

  assign addend = word_t'(bw_row(MAX_N'(a_r), MAX_N'(b_r), int'(cnt), N)) << cnt;

  ripple_adder #(.W(W)) u_add (.a(acc), .b(addend), .sum(sum));

  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    cnt_nxt     = cnt;
    a_nxt       = a_r;
    b_nxt       = b_r;
    product_nxt = product;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          a_nxt     = a;
          b_nxt     = b;
          cnt_nxt   = '0;
          acc_nxt   = CORR;
        end
      end
      RUN: begin
        acc_nxt = sum;
        cnt_nxt = cnt + CW'(1);
        if (cnt == CW'(N - 1)) begin
          state_nxt   = IDLE;
          cnt_nxt     = '0;
          product_nxt = sum;
          done_nxt    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      cnt     <= cnt_nxt;
      a_r     <= a_nxt;
      b_r     <= b_nxt;
      product <= product_nxt;
      done    <= done_nxt;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_bw_seq_mult.sv
// Scoreboard bench for bw_seq_mult: directed N=8 cases plus an exhaustive N=4 sweep.
module tb_bw_seq_mult;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;
  logic        start4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  prod4;

  int          checks = 0;
  int          failures = 0;
  longint      cyc = 0;
  longint      t0_8 = 0;
  longint      t0_4 = 0;
  logic [63:0] q8[$];
  logic [63:0] q4[$];
  int          dones8 = 0;
  logic        prev8 = 1'b0;
  logic        prev4 = 1'b0;
  int          bcnt;
  int          d0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bw_seq_mult #(.N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product(prod8)
  );

  bw_seq_mult #(.N(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .product(prod4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done8) begin
      dones8++;
      check("done8_width", 64'(prev8), 64'd0);
      check("done8_pending", 64'(q8.size() > 0), 64'd1);
      if (q8.size() > 0) check("prod8", {48'd0, prod8}, q8.pop_front());
    end
    prev8 = done8;
    if (rst_n && done4) begin
      check("done4_width", 64'(prev4), 64'd0);
      check("done4_pending", 64'(q4.size() > 0), 64'd1);
      if (q4.size() > 0) check("prod4", {56'd0, prod4}, q4.pop_front());
    end
    prev4 = done4;
  end

  task automatic drive8(input logic [7:0] a, input logic [7:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    start8 = 1'b1; a8 = a; b8 = b;
    q8.push_back({48'd0, p[15:0]});
    @(posedge clk); #1;
    t0_8 = cyc;
    start8 = 1'b0;
  endtask

  task automatic drive4(input logic [3:0] a, input logic [3:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    start4 = 1'b1; a4 = a; b4 = b;
    q4.push_back({56'd0, p[7:0]});
    @(posedge clk); #1;
    t0_4 = cyc;
    start4 = 1'b0;
  endtask

  task automatic wait_done8(output int busy_cycles);
    bit seen = 1'b0;
    busy_cycles = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if (done8) seen = 1'b1;
      else if (busy8) busy_cycles++;
    end
    check("done8_seen", 64'(seen), 64'd1);
    if (seen) begin
      check("lat8", 64'(cyc - t0_8), 64'd8);
      check("busy8_at_done", 64'(busy8), 64'd0);
    end
  endtask

  task automatic wait_done4;
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (done4) seen = 1'b1;
    end
    check("done4_seen", 64'(seen), 64'd1);
    if (seen) check("lat4", 64'(cyc - t0_4), 64'd4);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_done8", 64'(done8), 64'd0);
    check("rst_prod8", {48'd0, prod8}, 64'd0);
    check("rst_busy4", 64'(busy4), 64'd0);
    check("rst_prod4", {56'd0, prod4}, 64'd0);

    drive8(8'd3, 8'd5);
    wait_done8(bcnt);
    check("busy8_cycles", 64'(bcnt), 64'd8);

    @(negedge clk);
    drive8(8'h80, 8'h80);
    wait_done8(bcnt);
    drive8(8'hFF, 8'h01);
    wait_done8(bcnt);

    @(negedge clk);
    drive8(8'h7F, 8'h80);
    wait_done8(bcnt);
    @(negedge clk);
    drive8(8'h00, 8'hB3);
    wait_done8(bcnt);

    // start and operand changes during RUN must not disturb the result
    @(negedge clk);
    drive8(8'd7, 8'd9);
    d0 = dones8;
    repeat (4) @(negedge clk);
    start8 = 1'b1; a8 = 8'hCE; b8 = 8'h64;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'd11; b8 = 8'd22;
    wait_done8(bcnt);
    repeat (12) @(negedge clk);
    check("single_done8", 64'(dones8 - d0), 64'd1);

    // asynchronous abort between edges
    @(negedge clk);
    drive8(8'd5, 8'd6);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy8", 64'(busy8), 64'd0);
    check("abort_done8", 64'(done8), 64'd0);
    check("abort_prod8", {48'd0, prod8}, 64'd0);
    q8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    d0 = dones8;
    repeat (15) @(negedge clk);
    check("no_done_after_abort", 64'(dones8 - d0), 64'd0);
    drive8(8'hFD, 8'd7);
    wait_done8(bcnt);

    @(negedge clk);
    for (int ai = 0; ai < 16; ai++) begin
      for (int bi = 0; bi < 16; bi++) begin
        drive4(4'(ai), 4'(bi));
        wait_done4();
      end
    end

    repeat (4) @(negedge clk);
    check("q8_drained", 64'(q8.size()), 64'd0);
    check("q4_drained", 64'(q4.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
